map_table_nway: RTL and testbench

//  N-wide register alias table with branch checkpoints; next generation of the scalar RAT.

---
 rtl/map_table_nway_pkg.sv | 47 ++++
 rtl/map_table_nway_entry_update.sv | 34 +++
 rtl/map_table_nway.sv | 157 +++++++++++++++
 tb/tb_map_table_nway.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/map_table_nway_pkg.sv
// Shared types and sizing for the N-wide register alias table with branch checkpoints.
package map_table_nway_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned ARCH_IDX_W    = 5;
    localparam int unsigned ROB_TAG_W     = 5;
    localparam int unsigned DISPATCH_W    = 2;
    localparam int unsigned CDB_W         = 2;
    localparam int unsigned RETIRE_W      = 2;
    // Must stay a power of two: checkpoint pointers wrap by natural overflow.
    localparam int unsigned NUM_CKPT      = 4;
    localparam int unsigned CKPT_ID_W     = $clog2(NUM_CKPT);
    localparam int unsigned CKPT_CNT_W    = $clog2(NUM_CKPT + 1);

    localparam logic [ARCH_IDX_W-1:0] ZERO_REG = '0;

    typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

    typedef struct packed {
        logic                 valid;
        logic                 t_plus;
        logic [ROB_TAG_W-1:0] rob_tag;
    } map_packet_t;

    function automatic logic cdb_hit(input logic [CDB_W-1:0] vld,
                                     input logic [CDB_W-1:0][ROB_TAG_W-1:0] tags,
                                     input logic [ROB_TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(CDB_W); i++) begin
            if (vld[i] && tags[i] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic rt_hit(input logic [RETIRE_W-1:0] vld,
                                    input logic [RETIRE_W-1:0][ROB_TAG_W-1:0] tags,
                                    input logic [ROB_TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(RETIRE_W); i++) begin
            if (vld[i] && tags[i] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/map_table_nway_entry_update.sv
// Next-state of one alias-table entry: dispatch write beats retire clear beats CDB wakeup.
module map_table_nway_entry_update
    import map_table_nway_pkg::*;
(
    input  logic [ARCH_IDX_W-1:0]                 arch_idx,
    input  map_packet_t                           entry_cur,
    input  logic [DISPATCH_W-1:0]                 wr_en,
    input  logic [DISPATCH_W-1:0][ARCH_IDX_W-1:0] wr_idx,
    input  logic [DISPATCH_W-1:0][ROB_TAG_W-1:0]  wr_tag,
    input  logic [RETIRE_W-1:0]                   rt_valid,
    input  logic [RETIRE_W-1:0][ROB_TAG_W-1:0]    rt_tag,
    input  logic [CDB_W-1:0]                      cdb_valid,
    input  logic [CDB_W-1:0][ROB_TAG_W-1:0]       cdb_tag,
    output map_packet_t                           entry_nxt
);

    always_comb begin
        entry_nxt = entry_cur;
        if (entry_cur.valid && rt_hit(rt_valid, rt_tag, entry_cur.rob_tag)) begin
            entry_nxt = '0;
        end else if (entry_cur.valid && cdb_hit(cdb_valid, cdb_tag, entry_cur.rob_tag)) begin
            entry_nxt.t_plus = 1'b1;
        end
        // Ascending scan so the youngest slot writing this register wins.
        if (arch_idx != ZERO_REG) begin
            for (int s = 0; s < int'(DISPATCH_W); s++) begin
                if (wr_en[s] && wr_idx[s] == arch_idx) begin
                    entry_nxt = '{valid: 1'b1, t_plus: 1'b0, rob_tag: wr_tag[s]};
                end
            end
        end
    end

endmodule

// File: rtl/map_table_nway.sv
// N-wide register alias table: rename lookups with intra-group bypass, CDB/retire tracking,
// and a circular FIFO of branch checkpoints restored on mispredict.
module map_table_nway
    import map_table_nway_pkg::*;
(
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [DISPATCH_W-1:0]                 dp_valid,
    input  logic [DISPATCH_W-1:0]                 dp_has_dest,
    input  logic [DISPATCH_W-1:0][ARCH_IDX_W-1:0] dp_dest_idx,
    input  logic [DISPATCH_W-1:0][ROB_TAG_W-1:0]  dp_rob_tag,
    input  logic [DISPATCH_W-1:0][ARCH_IDX_W-1:0] dp_rs1_idx,
    input  logic [DISPATCH_W-1:0]                 dp_rs1_valid,
    input  logic [DISPATCH_W-1:0][ARCH_IDX_W-1:0] dp_rs2_idx,
    input  logic [DISPATCH_W-1:0]                 dp_rs2_valid,
    input  logic [DISPATCH_W-1:0]                 dp_ckpt_req,
    input  logic [CDB_W-1:0]                      cdb_valid,
    input  logic [CDB_W-1:0][ROB_TAG_W-1:0]       cdb_tag,
    input  logic [RETIRE_W-1:0]                   rt_valid,
    input  logic [RETIRE_W-1:0][ROB_TAG_W-1:0]    rt_tag,
    input  logic                                  br_valid,
    input  ckpt_id_t                              br_ckpt_id,
    input  logic                                  br_mispredict,
    output map_packet_t [DISPATCH_W-1:0]          src1_map,
    output map_packet_t [DISPATCH_W-1:0]          src2_map,
    output ckpt_id_t                              ckpt_id,
    output logic                                  ckpt_full,
    output map_packet_t [NUM_ARCH_REGS-1:0]       map_dbg
);

    map_packet_t [NUM_ARCH_REGS-1:0]               table_q, table_d, table_upd, snap;
    map_packet_t [NUM_CKPT-1:0][NUM_ARCH_REGS-1:0] ckpt_q, ckpt_d, ckpt_upd;
    ckpt_id_t                                      head_q, head_d, tail_q, tail_d;
    logic [CKPT_CNT_W-1:0]                         count_q, count_d;
    logic                                          ckpt_full_q, ckpt_full_d;

    logic [DISPATCH_W-1:0] dp_wr, snap_wr;
    logic take_req, take_act, br_legal, mispredict_act, resolve_ok;

    assign dp_wr = dp_valid & dp_has_dest;

    // Snapshot sees only slots up to and including the branch slot.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        snap_wr = '0;
        for (int s = 0; s < int'(DISPATCH_W); s++) begin
            snap_wr[s] = dp_wr[s] & ~seen;
            seen       = seen | (dp_valid[s] & dp_ckpt_req[s]);
        end
    end

    for (genvar r = 0; r < NUM_ARCH_REGS; r++) begin : g_reg
        map_table_nway_entry_update u_tbl (
            .arch_idx (ARCH_IDX_W'(r)), .entry_cur (table_q[r]),
            .wr_en    (dp_wr),          .wr_idx    (dp_dest_idx), .wr_tag (dp_rob_tag),
            .rt_valid (rt_valid),       .rt_tag    (rt_tag),
            .cdb_valid(cdb_valid),      .cdb_tag   (cdb_tag),     .entry_nxt (table_upd[r])
        );
        map_table_nway_entry_update u_snap (
            .arch_idx (ARCH_IDX_W'(r)), .entry_cur (table_q[r]),
            .wr_en    (snap_wr),        .wr_idx    (dp_dest_idx), .wr_tag (dp_rob_tag),
            .rt_valid (rt_valid),       .rt_tag    (rt_tag),
            .cdb_valid(cdb_valid),      .cdb_tag   (cdb_tag),     .entry_nxt (snap[r])
        );
        for (genvar c = 0; c < NUM_CKPT; c++) begin : g_ckpt
            map_table_nway_entry_update u_ckpt (
                .arch_idx (ARCH_IDX_W'(r)), .entry_cur (ckpt_q[c][r]),
                .wr_en    ('0),             .wr_idx    (dp_dest_idx), .wr_tag (dp_rob_tag),
                .rt_valid (rt_valid),       .rt_tag    (rt_tag),
                .cdb_valid(cdb_valid),      .cdb_tag   (cdb_tag),     .entry_nxt (ckpt_upd[c][r])
            );
        end
    end

    assign take_req       = |(dp_valid & dp_ckpt_req);
    assign br_legal       = br_valid && (count_q != '0) && (br_ckpt_id == head_q);
    assign mispredict_act = br_legal && br_mispredict;
    assign resolve_ok     = br_legal && !br_mispredict;
    assign take_act       = take_req && !ckpt_full_q && !mispredict_act;

    always_comb begin
        table_d = table_upd;
        ckpt_d  = ckpt_upd;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict_act) begin
            table_d = ckpt_upd[br_ckpt_id];
            tail_d  = br_ckpt_id;
            count_d = '0;
        end else begin
            if (take_act) begin
                ckpt_d[tail_q] = snap;
                tail_d         = tail_q + 1'b1;
            end
            if (resolve_ok) head_d = head_q + 1'b1;
            count_d = count_q + CKPT_CNT_W'(take_act) - CKPT_CNT_W'(resolve_ok);
        end
        ckpt_full_d = (count_d == CKPT_CNT_W'(NUM_CKPT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            table_q     <= '0;
            ckpt_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ckpt_full_q <= 1'b0;
        end else begin
            table_q     <= table_d;
            ckpt_q      <= ckpt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ckpt_full_q <= ckpt_full_d;
        end
    end

    function automatic map_packet_t lookup(input logic src_valid,
                                           input logic [ARCH_IDX_W-1:0] idx, input int slot);
        map_packet_t pkt;
        pkt = '0;
        if (src_valid && idx != ZERO_REG) begin
            pkt = table_q[idx];
            if (pkt.valid && cdb_hit(cdb_valid, cdb_tag, pkt.rob_tag)) pkt.t_plus = 1'b1;
            for (int i = 0; i < int'(DISPATCH_W); i++) begin
                if (i < slot && dp_wr[i] && dp_dest_idx[i] == idx) begin
                    pkt = '{valid: 1'b1, t_plus: 1'b0, rob_tag: dp_rob_tag[i]};
                end
            end
        end
        return pkt;
    endfunction

    always_comb begin
        src1_map = '0;
        src2_map = '0;
        for (int j = 0; j < int'(DISPATCH_W); j++) begin
            src1_map[j] = lookup(dp_rs1_valid[j], dp_rs1_idx[j], j);
            src2_map[j] = lookup(dp_rs2_valid[j], dp_rs2_idx[j], j);
        end
    end

    assign ckpt_id   = tail_q;
    assign ckpt_full = ckpt_full_q;
    assign map_dbg   = table_q;

    a_no_take_when_full: assert property (@(posedge clock) disable iff (reset)
        !(take_req && ckpt_full_q));
    a_one_ckpt_req: assert property (@(posedge clock) disable iff (reset)
        $onehot0(dp_valid & dp_ckpt_req));
    a_br_legal: assert property (@(posedge clock) disable iff (reset)
        br_valid |-> br_legal);

endmodule

// File: tb/tb_map_table_nway.sv
// Directed bench for map_table_nway: vector table for rename/bypass/CDB/retire/restore,
// hand sequences for checkpoint fill, wrap and reset.
module tb_map_table_nway;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      dp_valid, dp_has_dest, dp_rs1_valid, dp_rs2_valid, dp_ckpt_req;
    logic [1:0][4:0] dp_dest_idx, dp_rob_tag, dp_rs1_idx, dp_rs2_idx;
    logic [1:0]      cdb_valid, rt_valid;
    logic [1:0][4:0] cdb_tag, rt_tag;
    logic            br_valid, br_mispredict;
    logic [1:0]      br_ckpt_id, ckpt_id;
    logic [1:0][6:0] src1_map, src2_map;
    logic            ckpt_full;
    logic [31:0][6:0] map_dbg;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    map_table_nway dut (
        .clock(clock), .reset(reset),
        .dp_valid(dp_valid), .dp_has_dest(dp_has_dest), .dp_dest_idx(dp_dest_idx),
        .dp_rob_tag(dp_rob_tag), .dp_rs1_idx(dp_rs1_idx), .dp_rs1_valid(dp_rs1_valid),
        .dp_rs2_idx(dp_rs2_idx), .dp_rs2_valid(dp_rs2_valid), .dp_ckpt_req(dp_ckpt_req),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rt_valid(rt_valid), .rt_tag(rt_tag),
        .br_valid(br_valid), .br_ckpt_id(br_ckpt_id), .br_mispredict(br_mispredict),
        .src1_map(src1_map), .src2_map(src2_map), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .map_dbg(map_dbg)
    );

    typedef struct {
        logic [1:0]      dv, hd, ck, r1v, r2v, cv, rv;
        logic [1:0][4:0] dest, tag, r1, r2, ct, rtt;
        logic            bv, bm;
        logic [1:0]      bid;
        logic [1:0][6:0] e1;      // expected src1_map per slot
        logic [6:0]      e2;      // expected src2_map[1]
        logic [4:0]      ci;      // map_dbg index checked
        logic [6:0]      ed;
        logic [1:0]      eid;
        logic            ef;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic logic [6:0] pk(input int vb, input int tb, input int tag);
        return {vb[0], tb[0], tag[4:0]};
    endfunction

    task automatic apply(input vec_t v);
        dp_valid = v.dv; dp_has_dest = v.hd; dp_dest_idx = v.dest; dp_rob_tag = v.tag;
        dp_rs1_idx = v.r1; dp_rs1_valid = v.r1v; dp_rs2_idx = v.r2; dp_rs2_valid = v.r2v;
        dp_ckpt_req = v.ck; cdb_valid = v.cv; cdb_tag = v.ct; rt_valid = v.rv; rt_tag = v.rtt;
        br_valid = v.bv; br_ckpt_id = v.bid; br_mispredict = v.bm;
    endtask

    // Consume one clock edge, then present the vector mid-cycle.
    task automatic step(input vec_t v);
        @(posedge clock);
        #1;
        apply(v);
        #3;
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        apply(blank());
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        v = blank(); v.r1[0] = 5'd5; v.r1v = 2'b01;
        apply(v);
        #3;
        chk("rst src1[0]", src1_map[0], 7'd0);
        chk("rst full", 7'(ckpt_full), 7'd0);
        chk("rst ckpt_id", 7'(ckpt_id), 7'd0);
        chk("rst dbg r3", map_dbg[3], 7'd0);

        // 0-1: bypass then table write
        v = blank(); v.dv = 2'b11; v.hd = 2'b01; v.dest[0] = 5'd3; v.tag[0] = 5'd5;
        v.r1[1] = 5'd3; v.r1v = 2'b10; v.r2[1] = 5'd3; v.r2v = 2'b10;
        v.e1[1] = pk(1, 0, 5); v.e2 = pk(1, 0, 5); v.ci = 5'd3; vq.push_back(v);
        v = blank(); v.r1[0] = 5'd3; v.r1v = 2'b01; v.e1[0] = pk(1, 0, 5);
        v.ci = 5'd3; v.ed = pk(1, 0, 5); vq.push_back(v);
        // 2-6: CDB, retire, new mapping, stale retire
        v = blank(); v.cv = 2'b01; v.ct[0] = 5'd5; v.r1[0] = 5'd3; v.r1v = 2'b01;
        v.e1[0] = pk(1, 1, 5); v.ci = 5'd3; v.ed = pk(1, 0, 5); vq.push_back(v);
        v = blank(); v.rv = 2'b01; v.rtt[0] = 5'd5; v.r1[0] = 5'd3; v.r1v = 2'b01;
        v.e1[0] = pk(1, 1, 5); v.ci = 5'd3; v.ed = pk(1, 1, 5); vq.push_back(v);
        v = blank(); v.dv = 2'b11; v.hd = 2'b01; v.dest[0] = 5'd3; v.tag[0] = 5'd9;
        v.r1[1] = 5'd3; v.r1v = 2'b10; v.e1[1] = pk(1, 0, 9); v.ci = 5'd3; vq.push_back(v);
        v = blank(); v.rv = 2'b10; v.rtt[1] = 5'd5; v.ci = 5'd3; v.ed = pk(1, 0, 9);
        vq.push_back(v);
        v = blank(); v.r2[1] = 5'd3; v.r2v = 2'b10; v.e2 = pk(1, 0, 9);
        v.ci = 5'd3; v.ed = pk(1, 0, 9); vq.push_back(v);
        // 7-9: duplicate dest in a group, CDB forwarding on lookup
        v = blank(); v.dv = 2'b11; v.hd = 2'b11; v.dest[0] = 5'd7; v.dest[1] = 5'd7;
        v.tag[0] = 5'd2; v.tag[1] = 5'd3; v.r1[1] = 5'd7; v.r1v = 2'b10; v.r2[1] = 5'd7;
        v.r2v = 2'b10; v.e1[1] = pk(1, 0, 2); v.e2 = pk(1, 0, 2); v.ci = 5'd7; vq.push_back(v);
        v = blank(); v.cv = 2'b10; v.ct[1] = 5'd3; v.r1[0] = 5'd7; v.r1[1] = 5'd7;
        v.r1v = 2'b11; v.e1[0] = pk(1, 1, 3); v.e1[1] = pk(1, 1, 3);
        v.ci = 5'd7; v.ed = pk(1, 0, 3); vq.push_back(v);
        v = blank(); v.ci = 5'd7; v.ed = pk(1, 1, 3); vq.push_back(v);
        // 10-14: checkpoint, younger overwrite, CDB in window, mispredict restore
        v = blank(); v.dv = 2'b01; v.hd = 2'b01; v.dest[0] = 5'd1; v.tag[0] = 5'd4;
        v.ci = 5'd1; vq.push_back(v);
        v = blank(); v.dv = 2'b11; v.hd = 2'b10; v.ck = 2'b01; v.dest[1] = 5'd1;
        v.tag[1] = 5'd6; v.r1[1] = 5'd1; v.r1v = 2'b10; v.e1[1] = pk(1, 0, 4);
        v.ci = 5'd1; v.ed = pk(1, 0, 4); vq.push_back(v);
        v = blank(); v.cv = 2'b01; v.ct[0] = 5'd4; v.r1[0] = 5'd1; v.r1v = 2'b01;
        v.e1[0] = pk(1, 0, 6); v.ci = 5'd1; v.ed = pk(1, 0, 6); v.eid = 2'd1; vq.push_back(v);
        v = blank(); v.bv = 1'b1; v.bid = 2'd0; v.bm = 1'b1;
        v.ci = 5'd1; v.ed = pk(1, 0, 6); v.eid = 2'd1; vq.push_back(v);
        v = blank(); v.r1[0] = 5'd3; v.r1v = 2'b01; v.e1[0] = pk(1, 0, 9);
        v.ci = 5'd1; v.ed = pk(1, 1, 4); vq.push_back(v);
        // 15-16: writes to r0 dropped, lookups of r0 are zero
        v = blank(); v.dv = 2'b11; v.hd = 2'b01; v.dest[0] = 5'd0; v.tag[0] = 5'd1;
        v.r1[1] = 5'd0; v.r1v = 2'b10; v.ci = 5'd0; vq.push_back(v);
        v = blank(); v.r1[0] = 5'd0; v.r1[1] = 5'd7; v.r1v = 2'b11; v.e1[1] = pk(1, 1, 3);
        v.ci = 5'd0; vq.push_back(v);

        foreach (vq[i]) begin
            step(vq[i]);
            chk($sformatf("v%0d src1[0]", i), src1_map[0], vq[i].e1[0]);
            chk($sformatf("v%0d src1[1]", i), src1_map[1], vq[i].e1[1]);
            chk($sformatf("v%0d src2[1]", i), src2_map[1], vq[i].e2);
            chk($sformatf("v%0d dbg[%0d]", i, vq[i].ci), map_dbg[vq[i].ci], vq[i].ed);
            chk($sformatf("v%0d ckpt_id", i), 7'(ckpt_id), 7'(vq[i].eid));
            chk($sformatf("v%0d full", i), 7'(ckpt_full), 7'(vq[i].ef));
        end

        // Fill all four checkpoints
        for (int k = 0; k < 4; k++) begin
            v = blank(); v.dv = 2'b01; v.ck = 2'b01;
            step(v);
            chk($sformatf("fill%0d ckpt_id", k), 7'(ckpt_id), 7'(k));
            chk($sformatf("fill%0d full", k), 7'(ckpt_full), 7'd0);
        end
        v = blank(); v.bv = 1'b1; v.bid = 2'd0;
        step(v);
        chk("full after 4", 7'(ckpt_full), 7'd1);
        // Wrapped take together with resolve of id1: count holds
        v = blank(); v.dv = 2'b01; v.ck = 2'b01; v.bv = 1'b1; v.bid = 2'd1;
        step(v);
        chk("full after resolve", 7'(ckpt_full), 7'd0);
        chk("wrap ckpt_id", 7'(ckpt_id), 7'd0);
        v = blank(); v.dv = 2'b01; v.hd = 2'b01; v.dest[0] = 5'd5; v.tag[0] = 5'd12;
        step(v);
        chk("take+resolve ckpt_id", 7'(ckpt_id), 7'd1);
        chk("take+resolve full", 7'(ckpt_full), 7'd0);
        step(blank());
        chk("r5 mapped", map_dbg[5], pk(1, 0, 12));

        // Reset with live checkpoints and mappings
        @(posedge clock);
        #1;
        reset = 1'b1;
        apply(blank());
        @(posedge clock);
        #1;
        reset = 1'b0;
        v = blank(); v.r1[0] = 5'd5; v.r1v = 2'b01;
        apply(v);
        #3;
        for (int r = 0; r < 32; r++) chk($sformatf("post-rst dbg[%0d]", r), map_dbg[r], 7'd0);
        chk("post-rst full", 7'(ckpt_full), 7'd0);
        chk("post-rst ckpt_id", 7'(ckpt_id), 7'd0);
        chk("post-rst r5 lookup", src1_map[0], 7'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
